// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback sequencing and datapath selects.
// Optional macro FENCE_NOP_EN: decode FENCE as a legal no-op that retires through WRITEBACK.
module multicycle_control #(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_operation,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        regfile_we,
    output logic [1:0]  wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        illegal_instr,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [5:0] NREG         = 6'(NUM_REGS);

    state_t      state, state_nxt;
    logic        illegal_q, illegal_set;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        legal, uses_rd, uses_rs1, uses_rs2, reg_bad;
    logic        is_load, is_store, is_branch, is_jump, is_fence;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7    = instr[31:25];
    assign is_load   = opcode == OPC_LOAD;
    assign is_store  = opcode == OPC_STORE;
    assign is_branch = opcode == OPC_BRANCH;
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign is_fence  = opcode == OPC_MISC_MEM;

    // Encoding legality plus which register fields the instruction actually reads/writes.
    always_comb begin
        legal    = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
            end
            OPC_JALR: begin
                legal    = funct3 == 3'b000;
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                legal    = funct3 <= 3'b010;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001:  legal = funct7 == 7'b0000000;
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                legal    = (funct7 == 7'b0000000) ||
                           ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_MISC_MEM: begin
`ifdef FENCE_NOP_EN
                legal = funct3 == 3'b000;
`else
                legal = 1'b0;
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    assign reg_bad = (uses_rd  && ({1'b0, rd}  >= NREG)) ||
                     (uses_rs1 && ({1'b0, rs1} >= NREG)) ||
                     (uses_rs2 && ({1'b0, rs2} >= NREG));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q & ~rst;

    // Everything stays at its zero default while rst is high.
    always_comb begin
        state_nxt     = state;
        illegal_set   = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        imm_sel       = 3'd0;
        alu_operation = 4'd0;
        alu_a_sel     = 2'd0;
        alu_b_sel     = 1'b0;
        regfile_we    = 1'b0;
        wb_sel        = 2'd0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_size      = 2'd0;
        mem_unsigned  = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_size = 2'd2;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    if (opcode == OPC_SYSTEM) begin
                        state_nxt = TRAP;
                    end else if (!legal || reg_bad) begin
                        state_nxt   = TRAP;
                        illegal_set = 1'b1;
                    end else begin
                        state_nxt = EXECUTE;
                    end
                end
                EXECUTE: begin
                    case (opcode)
                        OPC_OP:     alu_operation = {instr[30], funct3};
                        OPC_OP_IMM: begin
                            alu_b_sel     = 1'b1;
                            alu_operation = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
                        end
                        OPC_LUI:    begin imm_sel = 3'd3; alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
                        OPC_AUIPC:  begin imm_sel = 3'd3; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                        OPC_JAL:    begin imm_sel = 3'd4; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                        OPC_BRANCH: begin imm_sel = 3'd2; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                        OPC_STORE:  begin imm_sel = 3'd1; alu_b_sel = 1'b1; end
                        OPC_JALR, OPC_LOAD: alu_b_sel = 1'b1;
                        default: ;
                    endcase
                    if (is_jump || (is_branch && branch_taken)) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    if (is_branch)                  state_nxt = FETCH;
                    else if (is_load || is_store)   state_nxt = MEMORY;
                    else                            state_nxt = WRITEBACK;
                end
                MEMORY: begin
                    mem_req      = 1'b1;
                    mem_we       = is_store;
                    mem_size     = funct3[1:0];
                    mem_unsigned = funct3[2];
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_we     = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = WRITEBACK;
                        end
                    end
                end
                WRITEBACK: begin
                    // A FENCE can only land here when it is enabled as a no-op.
                    regfile_we = ~is_fence;
                    wb_sel     = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
                    pc_we      = ~is_jump;
                    state_nxt  = FETCH;
                end
                TRAP:    halted = 1'b1;
                default: state_nxt = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors compared against hand-derived values.
module tb_multicycle_control;
    logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b1, branch_taken = 1'b0;
    logic [31:0] instr = 32'h0;

    logic ir_we, pc_we, pc_sel, alu_b_sel, regfile_we, mem_req, mem_we, mem_unsigned, illegal_instr, halted;
    logic [2:0] imm_sel;
    logic [3:0] alu_operation;
    logic [1:0] alu_a_sel, wb_sel, mem_size;
    logic ir_we_b, pc_we_b, pc_sel_b, alu_b_sel_b, regfile_we_b, mem_req_b, mem_we_b, mem_unsigned_b, illegal_instr_b, halted_b;
    logic [2:0] imm_sel_b;
    logic [3:0] alu_operation_b;
    logic [1:0] alu_a_sel_b, wb_sel_b, mem_size_b;

    int n_chk = 0, n_pass = 0;
    logic [22:0] SF, SWB, SWBL, SMEMW, STRAPI, STRAPS;

    always #5 clk = ~clk;

    multicycle_control #(.NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_operation(alu_operation),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .regfile_we(regfile_we), .wb_sel(wb_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .illegal_instr(illegal_instr), .halted(halted));

    multicycle_control #(.NUM_REGS(32)) dut32 (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_sel(pc_sel_b), .imm_sel(imm_sel_b), .alu_operation(alu_operation_b),
        .alu_a_sel(alu_a_sel_b), .alu_b_sel(alu_b_sel_b), .regfile_we(regfile_we_b), .wb_sel(wb_sel_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_size(mem_size_b), .mem_unsigned(mem_unsigned_b),
        .illegal_instr(illegal_instr_b), .halted(halted_b));

    function automatic logic [22:0] e(input int ir, pw, ps, im, op, asel, bsel, rw, wb, mr, mw, ms, mu, il, ht);
        return {1'(ir), 1'(pw), 1'(ps), 3'(im), 4'(op), 2'(asel), 1'(bsel), 1'(rw), 2'(wb),
                1'(mr), 1'(mw), 2'(ms), 1'(mu), 1'(il), 1'(ht)};
    endfunction

    function automatic logic [22:0] o16();
        return {ir_we, pc_we, pc_sel, imm_sel, alu_operation, alu_a_sel, alu_b_sel, regfile_we, wb_sel,
                mem_req, mem_we, mem_size, mem_unsigned, illegal_instr, halted};
    endfunction

    function automatic logic [22:0] o32();
        return {ir_we_b, pc_we_b, pc_sel_b, imm_sel_b, alu_operation_b, alu_a_sel_b, alu_b_sel_b, regfile_we_b,
                wb_sel_b, mem_req_b, mem_we_b, mem_size_b, mem_unsigned_b, illegal_instr_b, halted_b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Entered at posedge+1 with inputs set; samples at +2, returns at the next posedge+1.
    task automatic cyc2(input string tag, input logic [22:0] e16, input logic [22:0] e32);
        #1;
        chk(tag, 32'(o16()), 32'(e16));
        chk({tag, ".32"}, 32'(o32()), 32'(e32));
        @(posedge clk); #1;
    endtask

    task automatic cyc(input string tag, input logic [22:0] ex);
        cyc2(tag, ex, ex);
    endtask

    task automatic rst_seq(input string tag);
        rst = 1'b1;
        cyc({tag, ".rst0"}, 23'd0);
        cyc({tag, ".rst1"}, 23'd0);
        rst = 1'b0;
    endtask

    task automatic run4(input string tag, input logic [31:0] ins, input logic [22:0] ex_e, input logic [22:0] ex_w);
        instr = ins;
        cyc({tag, ".F"}, SF);
        cyc({tag, ".D"}, 23'd0);
        cyc({tag, ".E"}, ex_e);
        cyc({tag, ".W"}, ex_w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        SF     = e(1,0,0,0,0,0,0,0,0,1,0,2,0,0,0);
        SWB    = e(0,1,0,0,0,0,0,1,0,0,0,0,0,0,0);
        SWBL   = e(0,1,0,0,0,0,0,1,1,0,0,0,0,0,0);
        SMEMW  = e(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0);
        STRAPI = e(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1);
        STRAPS = e(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        @(posedge clk); #1;
        rst_seq("init");

        run4("addi",   32'h00500093, e(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0), SWB);
        run4("srai",   32'h4030D113, e(0,0,0,0,13,0,1,0,0,0,0,0,0,0,0), SWB);
        run4("srli",   32'h0030D113, e(0,0,0,0,5,0,1,0,0,0,0,0,0,0,0), SWB);
        run4("addin",  32'hC0000093, e(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0), SWB);
        run4("sub",    32'h402081B3, e(0,0,0,0,8,0,0,0,0,0,0,0,0,0,0), SWB);
        run4("lui",    32'h123452B7, e(0,0,0,3,0,2,1,0,0,0,0,0,0,0,0), SWB);
        run4("auipc",  32'h00001097, e(0,0,0,3,0,1,1,0,0,0,0,0,0,0,0), SWB);
        run4("jal",    32'h008000EF, e(0,1,1,4,0,1,1,0,0,0,0,0,0,0,0), e(0,0,0,0,0,0,0,1,2,0,0,0,0,0,0));
        run4("jalr",   32'h000100E7, e(0,1,1,0,0,0,1,0,0,0,0,0,0,0,0), e(0,0,0,0,0,0,0,1,2,0,0,0,0,0,0));

        // lw with memory completion held off three cycles
        instr = 32'h0000A183;
        cyc("lw.F", SF);
        cyc("lw.D", 23'd0);
        cyc("lw.E", e(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
        mem_ready = 1'b0;
        cyc("lw.M0", SMEMW);
        cyc("lw.M1", SMEMW);
        cyc("lw.M2", SMEMW);
        mem_ready = 1'b1;
        cyc("lw.M3", SMEMW);
        cyc("lw.W", SWBL);

        instr = 32'h0000C183;
        cyc("lbu.F", SF);
        cyc("lbu.D", 23'd0);
        cyc("lbu.E", e(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("lbu.M", e(0,0,0,0,0,0,0,0,0,1,0,0,1,0,0));
        cyc("lbu.W", SWBL);

        instr = 32'h00209323;
        cyc("sh.F", SF);
        cyc("sh.D", 23'd0);
        cyc("sh.E", e(0,0,0,1,0,0,1,0,0,0,0,0,0,0,0));
        cyc("sh.M", e(0,1,0,0,0,0,0,0,0,1,1,1,0,0,0));

        // fetch stalls while memory is not ready, then a taken branch
        instr = 32'h00000463;
        mem_ready = 1'b0;
        cyc("fwait", SMEMW);
        mem_ready = 1'b1;
        branch_taken = 1'b1;
        cyc("beqt.F", SF);
        cyc("beqt.D", 23'd0);
        cyc("beqt.E", e(0,1,1,2,0,1,1,0,0,0,0,0,0,0,0));
        branch_taken = 1'b0;
        cyc("beqn.F", SF);
        cyc("beqn.D", 23'd0);
        cyc("beqn.E", e(0,0,0,2,0,1,1,0,0,0,0,0,0,0,0));

`ifdef FENCE_NOP_EN
        run4("fence", 32'h0000000F, 23'd0, e(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0));
`else
        instr = 32'h0000000F;
        cyc("fence.F", SF);
        cyc("fence.D", 23'd0);
        cyc("fence.T", STRAPI);
        rst_seq("fence");
`endif

        // reset while a load waits in MEMORY
        instr = 32'h0000A183;
        cyc("mrst.F", SF);
        cyc("mrst.D", 23'd0);
        cyc("mrst.E", e(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
        mem_ready = 1'b0;
        cyc("mrst.M", SMEMW);
        rst_seq("mrst");
        mem_ready = 1'b1;

        instr = 32'h00000073;
        cyc("ecall.F", SF);
        cyc("ecall.D", 23'd0);
        cyc("ecall.T0", STRAPS);
        cyc("ecall.T1", STRAPS);
        rst_seq("ecall");

        instr = 32'h02000033;
        cyc("mul.F", SF);
        cyc("mul.D", 23'd0);
        cyc("mul.T", STRAPI);
        rst_seq("mul");

        // rd=x16: illegal on the 16-register build, ordinary add on the 32-register build
        instr = 32'h00000833;
        cyc("x16.F", SF);
        cyc("x16.D", 23'd0);
        cyc2("x16.E", STRAPI, 23'd0);
        cyc2("x16.W", STRAPI, SWB);
        cyc2("x16.X", STRAPI, SF);
        rst_seq("x16");
        cyc("x16.refetch", SF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 16, register-file depth: 16 (RV32E) or 32 (RV32I).
REQ-002 The block SHALL have ports: clk input 1, system clock; rst input 1, synchronous active-high reset, sampled on rising clk.
REQ-003 The block SHALL have ports: instr input 32, instruction register contents, stable from DECODE onward; mem_ready input 1, memory completion; branch_taken input 1, comparator result.
REQ-004 The block SHALL have ports: ir_we output 1, load instr register and latch PC+4; pc_we output 1, PC write enable; pc_sel output 1, 0=latched PC+4, 1=ALU result.
REQ-005 The block SHALL have ports: imm_sel output 3, I=0/S=1/B=2/U=3/J=4; alu_operation output 4; alu_a_sel output 2, 0=rs1/1=PC/2=zero; alu_b_sel output 1, 0=rs2/1=imm.
REQ-006 The block SHALL have ports: regfile_we output 1; wb_sel output 2, 0=ALU/1=memory/2=latched PC+4; mem_req, mem_we output 1 each; mem_size output 2, 0=byte/1=half/2=word; mem_unsigned output 1.
REQ-007 The block SHALL have ports: illegal_instr output 1, sticky illegal flag; halted output 1, high in TRAP.

Function
REQ-008 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; outputs decode combinationally from state and instr.
REQ-009 In FETCH, mem_req SHALL be 1 and mem_we 0, with mem_size=2; on mem_ready=1 in the same cycle, ir_we SHALL pulse and the next state SHALL be DECODE; otherwise FETCH holds.
REQ-010 mem_req SHALL stay high until mem_ready is sampled high; mem_ready SHALL be ignored while mem_req=0.
REQ-011 In DECODE, an unsupported opcode/funct, or any used rd/rs1/rs2 index >= NUM_REGS, SHALL go to TRAP; SYSTEM opcode SHALL go to TRAP with illegal_instr=0; otherwise the next state SHALL be EXECUTE.
REQ-012 alu_operation SHALL be {funct7[5],funct3} for OP; for OP_IMM, {funct7[5],funct3} only when funct3=101, else {0,funct3}; for LOAD/STORE/LUI/AUIPC/JAL/JALR/BRANCH it SHALL be 0000.
REQ-013 EXECUTE selects SHALL be: LUI zero+imm(U); AUIPC PC+imm(U); JAL PC+imm(J); JALR rs1+imm(I); BRANCH PC+imm(B); LOAD rs1+imm(I); STORE rs1+imm(S).
REQ-014 In EXECUTE, pc_we SHALL be 1 only for JAL, JALR and taken branches, with pc_sel=1; BRANCH SHALL then go to FETCH.
REQ-015 From EXECUTE, LOAD/STORE SHALL go to MEMORY; all other instructions SHALL go to WRITEBACK.
REQ-016 In MEMORY, mem_req SHALL be 1, mem_we SHALL be 1 for STORE, mem_size=funct3[1:0], and mem_unsigned=funct3[2]; on mem_ready, LOAD SHALL go to WRITEBACK and STORE SHALL go to FETCH with pc_we=1, pc_sel=0.
REQ-017 In WRITEBACK, regfile_we SHALL be 1 for exactly one cycle, with wb_sel=1 for LOAD, 2 for JAL/JALR, and 0 otherwise; pc_we=1, pc_sel=0 unless JAL/JALR; the next state SHALL be FETCH.
REQ-018 In TRAP, all write enables and mem_req SHALL be 0, halted SHALL be 1, and the state SHALL hold until rst.
REQ-019 Latency with mem_ready tied high SHALL be: ALU/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
REQ-020 Outputs not named for a state SHALL be 0 in that state; no write enable SHALL be asserted for more than one cycle per instruction.

Reset
REQ-021 While rst=1, all outputs SHALL be 0; the state SHALL become FETCH and illegal_instr SHALL clear.
REQ-022 rst asserted mid-transaction (MEMORY, or FETCH waiting) SHALL drop mem_req on the next cycle, suppress pending writes, and restart in FETCH.

Configuration
REQ-023 With macro FENCE_NOP_EN defined, FENCE SHALL decode as legal and retire via WRITEBACK with regfile_we=0, pc_we=1, pc_sel=0; without it, FENCE SHALL go to TRAP with illegal_instr=1.

Verification
REQ-024 addi x1,x0,5 (0x00500093), mem_ready=1 -> FETCH,DECODE,EXECUTE,WRITEBACK; imm_sel=0, alu_operation=0000, alu_b_sel=1, single regfile_we.
REQ-025 srai 0x4030D113 -> alu_operation=1101; srli 0x0030D113 -> 0101; addi -1024 0xC0000093 -> 0000.
REQ-026 lw x3,0(x1) 0x0000A183, mem_ready delayed 3 cycles in MEMORY -> mem_req held 4 cycles, mem_size=2, wb_sel=1, one regfile_we.
REQ-027 beq 0x00000463: branch_taken=1 -> pc_we=1, pc_sel=1 in EXECUTE; branch_taken=0 -> pc_we=0, then FETCH, 3 cycles total.
REQ-028 NUM_REGS=16, add x16,x0,x0 0x00000833 -> TRAP, illegal_instr=1, halted=1, no writes; NUM_REGS=32 -> normal retire; rst in TRAP -> FETCH.
REQ-029 FENCE 0x0000000F: with FENCE_NOP_EN -> retires in 4 cycles with regfile_we=0; without it -> TRAP, illegal_instr=1.
